// File: rtl/onehot_state_decoder.sv
// onehot_state_decoder: decodes and checks the 3-state one-hot bus.
// Optional ONEHOT_DEC_ARC_CHECK_EN enables forbidden-arc detection.
module onehot_state_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       st,
  input  logic             sample,
  output logic [1:0]       cur_idx,
  output logic [63:0]      cur_str,
  output logic             cur_valid,
  output logic [CNT_W-1:0] cnt_ab,
  output logic [CNT_W-1:0] cnt_bc,
  output logic [CNT_W-1:0] cnt_ca,
  output logic             illegal,
  output logic             bad_arc
);

  typedef enum logic {
    EMPTY,
    TRACK
  } mon_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [63:0] STR_A   = 64'h00_41_5F_53_54_41_54_45;
  localparam logic [63:0] STR_B   = 64'h00_42_5F_53_54_41_54_45;
  localparam logic [63:0] STR_C   = 64'h00_43_5F_53_54_41_54_45;
  localparam logic [63:0] STR_ILL = 64'h00_49_4C_4C_45_47_41_4C;

  mon_t        state;
  logic        hot;
  logic [1:0]  nidx;
  logic [63:0] nstr;
  logic        inc_ab;
  logic        inc_bc;
  logic        inc_ca;
  logic        trk;

  // Decode the observed vector and classify the arc it would form.
  always_comb begin
    hot  = 1'b1;
    nidx = 2'd0;
    nstr = STR_ILL;
    unique case (st)
      3'b001: begin
        nidx = 2'd0;
        nstr = STR_A;
      end
      3'b010: begin
        nidx = 2'd1;
        nstr = STR_B;
      end
      3'b100: begin
        nidx = 2'd2;
        nstr = STR_C;
      end
      default: hot = 1'b0;
    endcase
    trk    = sample && hot && (state == TRACK);
    inc_ab = trk && cur_idx == 2'd0 && nidx == 2'd1;
    inc_bc = trk && cur_idx == 2'd1 && nidx == 2'd2;
    inc_ca = trk && cur_idx == 2'd2 && nidx == 2'd0;
  end

`ifdef ONEHOT_DEC_ARC_CHECK_EN
  logic bad;

  // Any tracked arc that is neither counted nor an A/C self-loop.
  always_comb begin
    bad = trk && !(inc_ab || inc_bc || inc_ca)
        && !(cur_idx == nidx && cur_idx != 2'd1);
  end

  // Sticky forbidden-arc flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      bad_arc <= 1'b0;
    end else if (bad) begin
      bad_arc <= 1'b1;
    end
  end
`else
  assign bad_arc = 1'b0;
`endif

  // Monitor FSM with registered decode, counters and illegal flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      cur_idx   <= 2'd0;
      cur_str   <= 64'd0;
      cur_valid <= 1'b0;
      cnt_ab    <= '0;
      cnt_bc    <= '0;
      cnt_ca    <= '0;
      illegal   <= 1'b0;
    end else if (sample) begin
      cur_str <= nstr;
      if (hot) begin
        state     <= TRACK;
        cur_idx   <= nidx;
        cur_valid <= 1'b1;
      end else begin
        state     <= EMPTY;
        cur_valid <= 1'b0;
        illegal   <= 1'b1;
      end
      if (inc_ab && cnt_ab != CNT_MAX) begin
        cnt_ab <= cnt_ab + 1'b1;
      end
      if (inc_bc && cnt_bc != CNT_MAX) begin
        cnt_bc <= cnt_bc + 1'b1;
      end
      if (inc_ca && cnt_ca != CNT_MAX) begin
        cnt_ca <= cnt_ca + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_onehot_state_decoder.sv
// tb_onehot_state_decoder: scoreboard bench with a behavioural model.
// Drives a CNT_W=8 and a CNT_W=2 instance from the same stimulus.
module tb_onehot_state_decoder;

  logic clock = 1'b0;
  logic reset;
  logic [2:0] st;
  logic sample;

  logic [1:0]  idx8, idx2;
  logic [63:0] str8, str2;
  logic        val8, val2;
  logic [7:0]  ab8, bc8, ca8;
  logic [1:0]  ab2, bc2, ca2;
  logic        ill8, ill2, bad8, bad2;

  always #5 clock = ~clock;

  onehot_state_decoder #(.CNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .st(st), .sample(sample),
    .cur_idx(idx8), .cur_str(str8), .cur_valid(val8),
    .cnt_ab(ab8), .cnt_bc(bc8), .cnt_ca(ca8),
    .illegal(ill8), .bad_arc(bad8)
  );

  onehot_state_decoder #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .st(st), .sample(sample),
    .cur_idx(idx2), .cur_str(str2), .cur_valid(val2),
    .cnt_ab(ab2), .cnt_bc(bc2), .cnt_ca(ca2),
    .illegal(ill2), .bad_arc(bad2)
  );

  typedef struct {
    int          idx;
    logic [63:0] str;
    bit          valid;
    int          arcs[3];
    bit          ill;
    bit          bad;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // model state: prev = -1 means no legal previous state
  int          m_prev;
  int          m_idx;
  logic [63:0] m_str;
  int          m_arcs[3];
  bit          m_ill;
  bit          m_bad;
  logic [63:0] names[3];
  logic [63:0] ill_name;

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(bit r, bit s, logic [2:0] v);
    int n;
    if (r) begin
      m_prev = -1; m_idx = 0; m_str = '0;
      m_arcs = '{0, 0, 0}; m_ill = 0; m_bad = 0;
    end else if (s) begin
      if ($countones(v) == 1) begin
        n = 0;
        for (int i = 0; i < 3; i++) if (v[i]) n = i;
        if (m_prev >= 0) begin
          if (n == (m_prev + 1) % 3) m_arcs[m_prev]++;
          else if (!(n == m_prev && n != 1)) begin
`ifdef ONEHOT_DEC_ARC_CHECK_EN
            m_bad = 1;
`endif
          end
        end
        m_idx = n; m_str = names[n]; m_prev = n;
      end else begin
        m_ill = 1; m_str = ill_name; m_prev = -1;
      end
    end
  endtask

  // drive one edge and push the expected post-edge outputs
  task automatic step(bit r, bit s, logic [2:0] v);
    exp_t e;
    @(negedge clock);
    reset = r; sample = s; st = v;
    @(posedge clock);
    model(r, s, v);
    e.idx = m_idx; e.str = m_str; e.valid = (m_prev >= 0);
    e.arcs = m_arcs; e.ill = m_ill; e.bad = m_bad;
    q.push_back(e);
  endtask

  // monitor: compare both instances just after every edge
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("idx8", 64'(idx8), 64'(e.idx));
      chk("idx2", 64'(idx2), 64'(e.idx));
      chk("str8", str8, e.str);
      chk("str2", str2, e.str);
      chk("valid8", 64'(val8), 64'(e.valid));
      chk("valid2", 64'(val2), 64'(e.valid));
      chk("ab8", 64'(ab8), 64'(sat(e.arcs[0], 8)));
      chk("bc8", 64'(bc8), 64'(sat(e.arcs[1], 8)));
      chk("ca8", 64'(ca8), 64'(sat(e.arcs[2], 8)));
      chk("ab2", 64'(ab2), 64'(sat(e.arcs[0], 2)));
      chk("bc2", 64'(bc2), 64'(sat(e.arcs[1], 2)));
      chk("ca2", 64'(ca2), 64'(sat(e.arcs[2], 2)));
      chk("illegal8", 64'(ill8), 64'(e.ill));
      chk("illegal2", 64'(ill2), 64'(e.ill));
      chk("bad_arc8", 64'(bad8), 64'(e.bad));
      chk("bad_arc2", 64'(bad2), 64'(e.bad));
    end
  end

  initial begin
    logic [2:0] v;
    names[0] = "A_STATE";
    names[1] = "B_STATE";
    names[2] = "C_STATE";
    ill_name = "ILLEGAL";
    reset = 1'b1; sample = 1'b0; st = 3'b000;
    m_prev = -1;
    step(1, 0, 3'b000);
    step(1, 0, 3'b000);
    // legal loop A B C A
    step(0, 1, 3'b001);
    step(0, 1, 3'b010);
    step(0, 1, 3'b100);
    step(0, 1, 3'b001);
    // forbidden A->C
    step(0, 1, 3'b100);
    // illegal after A, then B starts a new trace
    step(0, 1, 3'b001);
    step(0, 1, 3'b011);
    step(0, 1, 3'b010);
    step(0, 1, 3'b000);
    step(0, 1, 3'b111);
    // self loops A, C and B
    step(0, 1, 3'b001);
    step(0, 1, 3'b001);
    step(0, 1, 3'b100);
    step(0, 1, 3'b100);
    step(0, 1, 3'b010);
    step(0, 1, 3'b010);
    // reset mid-trace with sample, then C counts no arc
    step(1, 1, 3'b010);
    step(0, 1, 3'b100);
    // hold with sample low while st toggles
    for (int i = 0; i < 8; i++) step(0, 0, 3'(i));
    // saturate: loop well past 255 arcs per counter
    step(1, 0, 3'b000);
    for (int i = 0; i < 260; i++) begin
      step(0, 1, 3'b001);
      step(0, 1, 3'b010);
      step(0, 1, 3'b100);
    end
    // saturating arc plus illegal and forbidden effects
    step(0, 1, 3'b001);
    step(0, 1, 3'b110);
    step(0, 1, 3'b001);
    step(0, 1, 3'b100);
    // randomized phase
    step(1, 0, 3'b000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) v = 3'(1 << $urandom_range(0, 2));
      else v = 3'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, v);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_state_decoder.md
# onehot_state_decoder

Observer for the three-state one-hot controller bus (`st[C:A]`, A=bit0, B=bit1, C=bit2) driven by the design's next-state logic. On each qualified sample it decodes the one-hot vector to a binary index and an 8-byte ASCII state name, and checks legality. It also counts legal transitions and flags malformed vectors or forbidden arcs. It sits beside the controller as the receive/decode end of the state bus, feeding debug displays and coverage checks.

## Interface
- `CNT_W`, 8, width of each arc counter; legal range 2..16
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `st`  in  3  observed one-hot state vector (bit0=A, bit1=B, bit2=C)
- `sample`  in  1  qualifies `st` for capture on this edge
- `cur_idx`  out  2  index of last legal sampled state (0=A, 1=B, 2=C)
- `cur_str`  out  64  ASCII name, right-justified, MSB byte 0x00 ("A_STATE", "B_STATE", "C_STATE", or "ILLEGAL")
- `cur_valid`  out  1  `cur_idx` holds a legal sampled state
- `cnt_ab`, `cnt_bc`, `cnt_ca`  out  CNT_W each  saturating counts of A->B, B->C, C->A arcs
- `illegal`  out  1  sticky: a sampled `st` was not exactly one-hot
- `bad_arc`  out  1  sticky: forbidden transition between legal states

## Operation
- Monitor FSM has two states:
  - EMPTY: no legal previous state.
  - TRACK: `cur_idx` is valid.
- Reset state is EMPTY. Reset values: `cur_idx`=0, `cur_str`=0, `cur_valid`=0, all counters 0, `illegal`=0, `bad_arc`=0.
- `sample`=0: every register holds.
- `sample`=1 and `st` is one-hot:
  - `cur_idx` and `cur_str` load the decoded value; `cur_valid`=1; FSM goes to TRACK.
  - If the FSM was in TRACK, the pair (previous idx, new idx) is classified:
    - A->A, C->C: legal self-loops, no count.
    - A->B: `cnt_ab` += 1.
    - B->C: `cnt_bc` += 1.
    - C->A: `cnt_ca` += 1.
    - A->C, B->A, B->B, C->B: forbidden; set `bad_arc`. No counter changes.
  - If the FSM was in EMPTY, no arc is evaluated.
- `sample`=1 and `st` is not one-hot (000, or two or more bits set):
  - `illegal` is set.
  - `cur_str`="ILLEGAL"; `cur_valid`=0; `cur_idx` holds its old value.
  - FSM goes to EMPTY, so the next legal sample starts a new trace without evaluating an arc.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Sticky flags clear only on reset.

## Timing
- Single-cycle latency: `st` sampled at edge N is reflected on all outputs after edge N. There is no combinational path from `st` to any output.
- `reset` has priority over `sample` on the same edge. Reset asserted mid-trace discards the previous state, so the first sample after reset never produces an arc.
- `sample` may be held high continuously; each edge is then an independent sample. Consecutive identical legal samples count as self-loops: ignored for A and C, `bad_arc` for B.
- A sample that both saturates a counter and sets a flag applies both effects on the same edge.

## Configuration
- `ONEHOT_DEC_ARC_CHECK_EN`:
  - Defined: forbidden-arc classification and `bad_arc` are implemented as described.
  - Undefined: `bad_arc` is tied to 0 and forbidden arcs are silently ignored. Decoding, counters and `illegal` are unchanged.

## Test plan
- Reset, then sample 001, 010, 100, 001 on consecutive edges -> `cnt_ab`=1, `cnt_bc`=1, `cnt_ca`=1, `cur_str`="A_STATE", both flags 0.
- Sample 001 then 100 -> `bad_arc`=1, counters unchanged. With macro undefined -> `bad_arc`=0.
- Sample 011 after a legal A -> `illegal`=1, `cur_valid`=0, `cur_str`="ILLEGAL". Then sample 010 -> no arc counted, `cur_idx`=1.
- With `CNT_W`=2, run the A->B->C->A loop 5 times -> each counter sticks at 3.
- Assert `reset` on the same edge as `sample`=1 with `st`=010 -> all outputs return to reset values. A following sample of 100 counts no arc.
- Hold `sample`=0 while toggling `st` -> all outputs stable.
